// File: rtl/paralelo_serial_param_if.sv
// Word handshake between a producer and the parallel-to-serial converter.
interface paralelo_serial_param_if #(
  parameter int WIDTH = 8
);
  logic [WIDTH-1:0] in_data;
  logic             valid_in;
  logic             ready_out;

  modport master (
    output in_data,
    output valid_in,
    input  ready_out
  );

  modport slave (
    input  in_data,
    input  valid_in,
    output ready_out
  );
endinterface

// File: rtl/paralelo_serial_param.sv
// Parallel-to-serial converter with idle fill and post-reset sync frames.
// Define PS_PARITY_EN to append an even parity bit to every frame.
module paralelo_serial_param #(
  parameter int               WIDTH      = 8,
  parameter logic [WIDTH-1:0] IDLE       = WIDTH'(8'hBC),
  parameter int               SYNC_WORDS = 4,
  parameter bit               LSB_FIRST  = 1'b0
) (
  input  logic                   clk_32f,
  input  logic                   reset,
  paralelo_serial_param_if.slave bus,
  output logic                   out_serial,
  output logic                   active_out
);
`ifdef PS_PARITY_EN
  localparam int FRAME = WIDTH + 1;
`else
  localparam int FRAME = WIDTH;
`endif
  localparam int CW = $clog2(FRAME);
  localparam int SW = (SYNC_WORDS > 1) ?
    $clog2(SYNC_WORDS) : 1;
  localparam logic [CW-1:0] LAST = CW'(FRAME - 1);
  localparam logic [SW-1:0] SYNC_LAST =
    SW'(SYNC_WORDS - 1);

  typedef enum logic [0:0] {
    S_SYNC,
    S_ACTIVE
  } state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [SW-1:0]    sync_q, sync_d;
  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic [WIDTH-1:0] hold_q, hold_d;
  logic             hold_full_q, hold_full_d;
  logic             active_q, active_d;
  logic             boundary;
  logic             ready;
  logic             accept;
  logic             line_bit;
`ifdef PS_PARITY_EN
  logic             par_q, par_d;
`endif

  assign boundary = cnt_q == LAST;
  assign ready    = (state_q == S_ACTIVE) &&
                    !hold_full_q;
  assign accept   = bus.valid_in && ready;

  assign bus.ready_out = ready;
  assign active_out    = active_q;

  // the register shifts so the bit on the line is always at one end
  assign line_bit = LSB_FIRST ? shreg_q[0] :
                                shreg_q[WIDTH-1];
`ifdef PS_PARITY_EN
  assign out_serial = (cnt_q == CW'(WIDTH)) ?
                      par_q : line_bit;
`else
  assign out_serial = line_bit;
`endif

  always_comb begin
    state_d     = state_q;
    sync_d      = sync_q;
    cnt_d       = cnt_q + CW'(1);
    shreg_d     = LSB_FIRST ? (shreg_q >> 1) :
                              (shreg_q << 1);
    hold_d      = hold_q;
    hold_full_d = hold_full_q;
    active_d    = active_q;
`ifdef PS_PARITY_EN
    par_d       = par_q;
`endif
    if (boundary) begin
      cnt_d = '0;
      unique case (1'b1)
        hold_full_q: begin
          shreg_d     = hold_q;
          hold_full_d = 1'b0;
          active_d    = 1'b1;
        end
        default: begin
          shreg_d  = IDLE;
          active_d = 1'b0;
          if (state_q == S_SYNC) begin
            sync_d = sync_q + SW'(1);
            if (sync_q == SYNC_LAST)
              state_d = S_ACTIVE;
          end
        end
      endcase
`ifdef PS_PARITY_EN
      par_d = ^shreg_d;
`endif
    end
    // never coincides with a drain: accept needs an empty holder
    if (accept) begin
      hold_d      = bus.in_data;
      hold_full_d = 1'b1;
    end
  end

  always_ff @(posedge clk_32f) begin
    if (reset) begin
      state_q     <= S_SYNC;
      sync_q      <= '0;
      cnt_q       <= LAST;
      shreg_q     <= '0;
      hold_q      <= '0;
      hold_full_q <= 1'b0;
      active_q    <= 1'b0;
`ifdef PS_PARITY_EN
      par_q       <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      sync_q      <= sync_d;
      cnt_q       <= cnt_d;
      shreg_q     <= shreg_d;
      hold_q      <= hold_d;
      hold_full_q <= hold_full_d;
      active_q    <= active_d;
`ifdef PS_PARITY_EN
      par_q       <= par_d;
`endif
    end
  end
endmodule

// File: tb/tb_paralelo_serial_param.sv
// Bench for paralelo_serial_param: frame-level reference model,
// directed test-plan steps plus randomized traffic.
module tb_paralelo_serial_param;
  localparam int W    = 8;
  localparam int SYNC = 4;
  localparam int W2   = 10;
`ifdef PS_PARITY_EN
  localparam int FRAME = W + 1;
  localparam int F2    = W2 + 1;
`else
  localparam int FRAME = W;
  localparam int F2    = W2;
`endif
  localparam int RISE = (SYNC - 1) * FRAME + 1;
  localparam logic [W-1:0]  IDLE_V  = 8'hBC;
  localparam logic [W2-1:0] IDLE2_V = 10'h17C;

  logic clk;
  logic reset;
  logic rst2;
  logic out1, act1;
  logic out2, act2;

  paralelo_serial_param_if #(.WIDTH(W))  bus1();
  paralelo_serial_param_if #(.WIDTH(W2)) bus2();

  paralelo_serial_param dut (
    .clk_32f    (clk),
    .reset      (reset),
    .bus        (bus1),
    .out_serial (out1),
    .active_out (act1)
  );

  paralelo_serial_param #(
    .WIDTH     (W2),
    .IDLE      (IDLE2_V),
    .LSB_FIRST (1'b1)
  ) dut2 (
    .clk_32f    (clk),
    .reset      (rst2),
    .bus        (bus2),
    .out_serial (out2),
    .active_out (act2)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int vecs = 0;
  int errs = 0;

  // reference model: which word occupies the current frame and where
  int           m_pos;
  logic [W-1:0] m_word;
  logic         m_active;
  logic         m_full;
  logic [W-1:0] m_hold;
  int           m_loads;
  logic         m_synced;

  logic [W-1:0] b2b [3] = '{8'h01, 8'hFF, 8'h3C};

  function automatic logic msb_bit(
    input logic [W-1:0] w, input int p);
    if (p < W) return w[W-1-p];
    return ^w;
  endfunction

  function automatic logic lsb_bit(
    input logic [W2-1:0] w, input int p);
    if (p < W2) return w[p];
    return ^w;
  endfunction

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    vecs++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed %0h expected %0h",
             tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_pos    = FRAME - 1;
    m_word   = '0;
    m_active = 1'b0;
    m_full   = 1'b0;
    m_hold   = '0;
    m_loads  = 0;
    m_synced = 1'b0;
  endtask

  task automatic step();
    logic         r, acc;
    logic [W-1:0] d;
    r   = reset;
    d   = bus1.in_data;
    acc = bus1.valid_in && m_synced && !m_full;
    @(posedge clk);
    if (r) begin
      model_reset();
    end else begin
      if (m_pos == FRAME - 1) begin
        m_pos = 0;
        if (m_full) begin
          m_word   = m_hold;
          m_full   = 1'b0;
          m_active = 1'b1;
        end else begin
          m_word   = IDLE_V;
          m_active = 1'b0;
          if (!m_synced) begin
            m_loads++;
            if (m_loads == SYNC) m_synced = 1'b1;
          end
        end
      end else begin
        m_pos++;
      end
      if (acc) begin
        m_hold = d;
        m_full = 1'b1;
      end
    end
    #1;
    chk("out_serial", out1, msb_bit(m_word, m_pos));
    chk("ready_out", bus1.ready_out,
        m_synced && !m_full);
    chk("active_out", act1, m_active);
  endtask

  initial begin
    int   got, idx, run, maxrun, n, act_cnt;
    logic acc, hit, found;
    reset = 1'b1;
    rst2  = 1'b1;
    bus1.valid_in = 1'b0;
    bus1.in_data  = '0;
    bus2.valid_in = 1'b0;
    bus2.in_data  = '0;
    model_reset();

    repeat (3) step();
    chk("rst_out", out1, 0);
    chk("rst_ready", bus1.ready_out, 0);
    chk("rst_active", act1, 0);

    // sync idles and the ready rise
    reset = 1'b0;
    for (int i = 1; i <= RISE; i++) begin
      step();
      if (i <= 2 * FRAME)
        chk("sync_bit", out1,
            msb_bit(IDLE_V, (i - 1) % FRAME));
      if (i == RISE - 1)
        chk("ready_early", bus1.ready_out, 0);
    end
    chk("ready_rise", bus1.ready_out, 1);

    // single word
    bus1.valid_in = 1'b1;
    bus1.in_data  = 8'hA5;
    step();
    bus1.valid_in = 1'b0;
    got = 0;
    for (int i = 0; i < 4 * FRAME && got < FRAME; i++) begin
      step();
      if (act1) begin
        chk("a5_bit", out1, msb_bit(8'hA5, got));
        got++;
      end
    end
    chk("a5_len", got, FRAME);
    step();
    chk("a5_tail", act1, 0);

    // back-to-back words
    idx = 0; run = 0; maxrun = 0;
    bus1.valid_in = 1'b1;
    bus1.in_data  = b2b[0];
    for (int i = 0; i < 8 * FRAME; i++) begin
      acc = bus1.valid_in && m_synced && !m_full;
      step();
      if (acc) begin
        idx++;
        if (idx < 3) bus1.in_data = b2b[idx];
        else bus1.valid_in = 1'b0;
      end
      if (act1) run++;
      else run = 0;
      if (run > maxrun) maxrun = run;
    end
    chk("b2b_accepts", idx, 3);
    chk("b2b_run", maxrun, 3 * FRAME);

    // random traffic, data held stable until accepted
    acc = 1'b0;
    for (int i = 0; i < 400; i++) begin
      if (!bus1.valid_in || acc) begin
        bus1.valid_in = 1'($urandom_range(0, 1));
        bus1.in_data  = 8'($urandom);
      end
      acc = bus1.valid_in && m_synced && !m_full;
      step();
    end

    // reset at bit 3 of a data frame with a word held
    bus1.valid_in = 1'b1;
    bus1.in_data  = 8'h5A;
    n = 0; hit = 1'b0;
    for (int i = 0; i < 6 * FRAME && !hit; i++) begin
      acc = bus1.valid_in && m_synced && !m_full;
      step();
      if (acc) begin
        n++;
        if (n == 1) bus1.in_data = 8'hC3;
        else bus1.valid_in = 1'b0;
      end
      if (n == 2 && m_active && m_pos == 3 &&
          m_word == 8'h5A)
        hit = 1'b1;
    end
    chk("mid_hit", hit, 1);
    reset = 1'b1;
    step();
    chk("mid_rst_out", out1, 0);
    chk("mid_rst_ready", bus1.ready_out, 0);
    reset = 1'b0;
    act_cnt = 0;
    for (int i = 1; i <= RISE + 2 * FRAME; i++) begin
      step();
      if (act1) act_cnt++;
      if (i == RISE - 1)
        chk("resync_early", bus1.ready_out, 0);
      if (i == RISE)
        chk("resync_rise", bus1.ready_out, 1);
    end
    chk("held_dropped", act_cnt, 0);

    // LSB-first 10-bit instance
    rst2 = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 8 * F2 && !found; i++) begin
      @(posedge clk);
      #1;
      if (bus2.ready_out) found = 1'b1;
    end
    chk("lsb_ready", found, 1);
    if (found) begin
      for (int i = 0; i < 2 * F2; i++) begin
        if (i > 0) begin
          @(posedge clk);
          #1;
        end
        if (i < F2)
          chk("lsb_idle_bit", out2, lsb_bit(IDLE2_V, i));
        else
          chk("lsb_data_bit", out2,
              lsb_bit(10'h2A5, i - F2));
        chk("lsb_active", act2, (i >= F2) ? 1 : 0);
        if (i == 0) begin
          bus2.valid_in = 1'b1;
          bus2.in_data  = 10'h2A5;
        end else begin
          bus2.valid_in = 1'b0;
        end
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==",
             vecs, errs);
    $finish;
  end
endmodule
